// File: rtl/matvec_mac_if.sv
// matvec_mac_if: operand/result bundle between the fetch stage, the matvec_mac
// engine and the downstream result writer.
//   start        : request to compute (sampled by the engine only while idle)
//   A[0:63]      : 8x8 matrix, row-major, 8-bit unsigned elements
//   B[0:7]       : 8-entry vector, 8-bit unsigned elements
//   C[0:7]       : 24-bit result vector, held between completions
//   busy         : engine is not idle
//   done         : one-cycle completion strobe
// master modport = requester side, slave modport = engine side.
interface matvec_mac_if;
    logic        start;
    logic [7:0]  A [0:63];
    logic [7:0]  B [0:7];
    logic [23:0] C [0:7];
    logic        busy;
    logic        done;

    modport master (output start, A, B, input C, busy, done);
    modport slave  (input start, A, B, output C, busy, done);
endinterface

// File: rtl/matvec_mac.sv
// matvec_mac: computes C = A*B for an 8x8 matrix of 8-bit unsigned values and
// an 8-entry vector, using eight parallel multiply-accumulate lanes that walk
// one matrix column per clock.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : matvec_mac_if.slave (start, A, B in; C, busy, done out)
//
// Optional build macro:
//   MAC_PIPE_EN : inserts a product register between each multiplier and its
//                 accumulator (adds a DRAIN state and one cycle of latency).
//                 Results are identical with or without it.
//
// Operands are captured on start so the requester may change A/B freely
// afterwards. All outputs are registered.
module matvec_mac (
    input  logic         clk,
    input  logic         rst_n,
    matvec_mac_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  a_q   [0:63];
    logic [7:0]  b_q   [0:7];
    logic [23:0] acc_q [0:7];
    logic [23:0] c_q   [0:7];
    logic [2:0]  k_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] prod_s [0:7];
    logic [23:0] acc_d  [0:7];

`ifdef MAC_PIPE_EN
    logic [15:0] prod_q [0:7];
`endif

    // Per-lane product for the current column and the next accumulator value.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            // Lane i reads row i, column k: index {i, k} == i*8 + k.
            prod_s[i] = a_q[{3'(i), k_q}] * b_q[k_q];
`ifdef MAC_PIPE_EN
            // Accumulate the product registered on the previous cycle.
            acc_d[i]  = acc_q[i] + {8'd0, prod_q[i]};
`else
            acc_d[i]  = acc_q[i] + {8'd0, prod_s[i]};
`endif
        end
    end

    // Control FSM, operand capture, accumulation and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int n = 0; n < 64; n++) begin
                a_q[n] <= 8'd0;
            end
            for (int i = 0; i < 8; i++) begin
                b_q[i]   <= 8'd0;
                acc_q[i] <= 24'd0;
                c_q[i]   <= 24'd0;
`ifdef MAC_PIPE_EN
                prod_q[i] <= 16'd0;
`endif
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        for (int n = 0; n < 64; n++) begin
                            a_q[n] <= bus.A[n];
                        end
                        for (int i = 0; i < 8; i++) begin
                            b_q[i]   <= bus.B[i];
                            acc_q[i] <= 24'd0;
`ifdef MAC_PIPE_EN
                            // Cleared so the first RUN cycle adds zero.
                            prod_q[i] <= 16'd0;
`endif
                        end
                        k_q     <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_RUN: begin
                    for (int i = 0; i < 8; i++) begin
                        acc_q[i] <= acc_d[i];
`ifdef MAC_PIPE_EN
                        prod_q[i] <= prod_s[i];
`endif
                    end
                    // Wraps 7 -> 0 on the exit transition.
                    k_q <= k_q + 3'd1;
                    if (k_q == 3'd7) begin
`ifdef MAC_PIPE_EN
                        state_q <= S_DRAIN;
`else
                        for (int i = 0; i < 8; i++) begin
                            c_q[i] <= acc_d[i];
                        end
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end else begin
                        state_q <= S_RUN;
                    end
                end

                S_DRAIN: begin
`ifdef MAC_PIPE_EN
                    // Fold in the last registered product (column 7).
                    for (int i = 0; i < 8; i++) begin
                        acc_q[i] <= acc_d[i];
                        c_q[i]   <= acc_d[i];
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
`else
                    // Unreachable without the pipeline option; recover to idle.
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
`endif
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.C    = c_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
